// File: rtl/ex_mem_register.sv
// EX/MEM pipeline register with stall, flush, valid gating and forwarding info.
// Optional perf counters are enabled with EX_MEM_PERF_COUNTERS_EN.
module ex_mem_register #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      validInput,
  input  logic                      memToRegInput,
  input  logic                      regWriteInput,
  input  logic                      memWriteInput,
  input  logic                      memReadInput,
  input  logic [DATA_WIDTH-1:0]     aluResultInput,
  input  logic [DATA_WIDTH-1:0]     memWriteDataInput,
  input  logic [REG_ADDR_WIDTH-1:0] regWriteAddressInput,
  output logic                      validOutput,
  output logic                      memToRegOutput,
  output logic                      regWriteOutput,
  output logic                      memWriteOutput,
  output logic                      memReadOutput,
  output logic [DATA_WIDTH-1:0]     aluResultOutput,
  output logic [DATA_WIDTH-1:0]     memWriteDataOutput,
  output logic [REG_ADDR_WIDTH-1:0] regWriteAddressOutput,
`ifdef EX_MEM_PERF_COUNTERS_EN
  output logic [31:0]               retiredCountOutput,
  output logic [31:0]               bubbleCountOutput,
  output logic [31:0]               stallCountOutput,
`endif
  output logic                      forwardEnableOutput,
  output logic                      loadPendingOutput
);

  logic                      valid_q;
  logic                      mem_to_reg_q;
  logic                      reg_write_q;
  logic                      mem_write_q;
  logic                      mem_read_q;
  logic [DATA_WIDTH-1:0]     alu_q;
  logic [DATA_WIDTH-1:0]     wdata_q;
  logic [REG_ADDR_WIDTH-1:0] addr_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      alu_q        <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
    end else if (flush) begin
      valid_q      <= 1'b0;
      mem_to_reg_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      alu_q        <= '0;
      wdata_q      <= '0;
      addr_q       <= '0;
    end else if (!stall) begin
      // Bubbles keep their data but never carry side-effecting control.
      valid_q      <= validInput;
      mem_to_reg_q <= memToRegInput & validInput;
      reg_write_q  <= regWriteInput & validInput;
      mem_write_q  <= memWriteInput & validInput;
      mem_read_q   <= memReadInput & validInput;
      alu_q        <= aluResultInput;
      wdata_q      <= memWriteDataInput;
      addr_q       <= regWriteAddressInput;
    end
  end

  assign validOutput           = valid_q;
  assign memToRegOutput        = mem_to_reg_q;
  assign regWriteOutput        = reg_write_q;
  assign memWriteOutput        = mem_write_q;
  assign memReadOutput         = mem_read_q;
  assign aluResultOutput       = alu_q;
  assign memWriteDataOutput    = wdata_q;
  assign regWriteAddressOutput = addr_q;

  assign forwardEnableOutput = valid_q & reg_write_q & ~mem_to_reg_q
                             & (addr_q != '0);
  assign loadPendingOutput   = valid_q & mem_read_q & mem_to_reg_q;

`ifdef EX_MEM_PERF_COUNTERS_EN
  logic [31:0] retired_q;
  logic [31:0] bubble_q;
  logic [31:0] stall_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      retired_q <= '0;
      bubble_q  <= '0;
      stall_q   <= '0;
    end else if (flush) begin
      bubble_q <= bubble_q + 32'd1;
    end else if (stall) begin
      stall_q <= stall_q + 32'd1;
    end else if (validInput) begin
      retired_q <= retired_q + 32'd1;
    end else begin
      bubble_q <= bubble_q + 32'd1;
    end
  end

  assign retiredCountOutput = retired_q;
  assign bubbleCountOutput  = bubble_q;
  assign stallCountOutput   = stall_q;
`endif

endmodule

// File: tb/tb_ex_mem_register.sv
// Scoreboard bench for ex_mem_register: directed plan then random traffic.
// Counter checks are included when EX_MEM_PERF_COUNTERS_EN is defined.
module tb_ex_mem_register;

  typedef struct packed {
    logic        v;
    logic        mt;
    logic        rw;
    logic        mw;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  ad;
    logic        fwd;
    logic        ldp;
`ifdef EX_MEM_PERF_COUNTERS_EN
    logic [31:0] ret;
    logic [31:0] bub;
    logic [31:0] stl;
`endif
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        valid_in = 1'b0;
  logic        mt_in = 1'b0;
  logic        rw_in = 1'b0;
  logic        mw_in = 1'b0;
  logic        mr_in = 1'b0;
  logic [31:0] alu_in = '0;
  logic [31:0] wd_in = '0;
  logic [4:0]  ad_in = '0;

  logic        valid_out;
  logic        mt_out;
  logic        rw_out;
  logic        mw_out;
  logic        mr_out;
  logic [31:0] alu_out;
  logic [31:0] wd_out;
  logic [4:0]  ad_out;
  logic        fwd_out;
  logic        ldp_out;
`ifdef EX_MEM_PERF_COUNTERS_EN
  logic [31:0] ret_out;
  logic [31:0] bub_out;
  logic [31:0] stl_out;
`endif

  ex_mem_register dut (
    .clk                   (clk),
    .reset                 (reset),
    .stall                 (stall),
    .flush                 (flush),
    .validInput            (valid_in),
    .memToRegInput         (mt_in),
    .regWriteInput         (rw_in),
    .memWriteInput         (mw_in),
    .memReadInput          (mr_in),
    .aluResultInput        (alu_in),
    .memWriteDataInput     (wd_in),
    .regWriteAddressInput  (ad_in),
    .validOutput           (valid_out),
    .memToRegOutput        (mt_out),
    .regWriteOutput        (rw_out),
    .memWriteOutput        (mw_out),
    .memReadOutput         (mr_out),
    .aluResultOutput       (alu_out),
    .memWriteDataOutput    (wd_out),
    .regWriteAddressOutput (ad_out),
`ifdef EX_MEM_PERF_COUNTERS_EN
    .retiredCountOutput    (ret_out),
    .bubbleCountOutput     (bub_out),
    .stallCountOutput      (stl_out),
`endif
    .forwardEnableOutput   (fwd_out),
    .loadPendingOutput     (ldp_out)
  );

  always #5 clk = ~clk;

  obs_t        expq[$];
  int          checks = 0;
  int          errors = 0;

  // Reference state: what the slot holds, as an instruction record.
  logic        m_v, m_mt, m_rw, m_mw, m_mr;
  logic [31:0] m_alu, m_wd;
  logic [4:0]  m_ad;
  logic [31:0] m_ret, m_bub, m_stl;

  function automatic obs_t snap();
    obs_t o;
    o.v   = m_v;
    o.mt  = m_mt;
    o.rw  = m_rw;
    o.mw  = m_mw;
    o.mr  = m_mr;
    o.alu = m_alu;
    o.wd  = m_wd;
    o.ad  = m_ad;
    // A result is forwardable only from a real ALU-writing op to a nonzero reg.
    o.fwd = m_v && m_rw && !m_mt && m_ad != 0;
    o.ldp = m_v && m_mr && m_mt;
`ifdef EX_MEM_PERF_COUNTERS_EN
    o.ret = m_ret;
    o.bub = m_bub;
    o.stl = m_stl;
`endif
    return o;
  endfunction

  task automatic clear_slot();
    m_v = 0; m_mt = 0; m_rw = 0; m_mw = 0; m_mr = 0;
    m_alu = 0; m_wd = 0; m_ad = 0;
  endtask

  task automatic step(input bit rst_n, input bit st, input bit fl,
                      input bit v, input bit mt, input bit rw,
                      input bit mw, input bit mr,
                      input logic [31:0] a, input logic [31:0] d,
                      input logic [4:0] ad);
    @(posedge clk);
    #2;
    reset = rst_n; stall = st; flush = fl; valid_in = v;
    mt_in = mt; rw_in = rw; mw_in = mw; mr_in = mr;
    alu_in = a; wd_in = d; ad_in = ad;
    if (!rst_n) begin
      clear_slot();
      m_ret = 0; m_bub = 0; m_stl = 0;
    end else if (fl) begin
      clear_slot();
      m_bub = m_bub + 1;
    end else if (st) begin
      m_stl = m_stl + 1;
    end else begin
      m_v = v;
      m_mt = v && mt; m_rw = v && rw; m_mw = v && mw; m_mr = v && mr;
      m_alu = a; m_wd = d; m_ad = ad;
      if (v) m_ret = m_ret + 1;
      else m_bub = m_bub + 1;
    end
    expq.push_back(snap());
  endtask

  // Monitor: each edge, compare the slot against the oldest expectation.
  initial begin
    obs_t a, e;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        a.v = valid_out; a.mt = mt_out; a.rw = rw_out;
        a.mw = mw_out; a.mr = mr_out; a.alu = alu_out;
        a.wd = wd_out; a.ad = ad_out; a.fwd = fwd_out; a.ldp = ldp_out;
`ifdef EX_MEM_PERF_COUNTERS_EN
        a.ret = ret_out; a.bub = bub_out; a.stl = stl_out;
`endif
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL slot t=%0t got v%b mt%b rw%b mw%b mr%b alu=%h wd=%h ad=%0d fwd%b ldp%b exp v%b mt%b rw%b mw%b mr%b alu=%h wd=%h ad=%0d fwd%b ldp%b",
                   $time, a.v, a.mt, a.rw, a.mw, a.mr, a.alu, a.wd, a.ad,
                   a.fwd, a.ldp, e.v, e.mt, e.rw, e.mw, e.mr, e.alu, e.wd,
                   e.ad, e.fwd, e.ldp);
`ifdef EX_MEM_PERF_COUNTERS_EN
          $display("FAIL counters got %0d/%0d/%0d exp %0d/%0d/%0d",
                   a.ret, a.bub, a.stl, e.ret, e.bub, e.stl);
`endif
        end
      end
    end
  end

  initial begin
    logic [31:0] ones;
    ones = 32'hFFFF_FFFF;
    clear_slot();
    m_ret = 0; m_bub = 0; m_stl = 0;
    // Reset and basic forwardable load
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 1, 1, 1, ones, ones, 5'd31);
    step(1, 0, 0, 1, 0, 1, 0, 0, 32'h1234, 32'h55, 5'd5);
    // Bubble with side-effecting controls requested
    step(1, 0, 0, 0, 0, 1, 1, 0, 32'hABCD, 32'h77, 5'd9);
    // lw then three stalls with changing inputs
    step(1, 0, 0, 1, 1, 0, 0, 1, 32'h100, 32'h0, 5'd8);
    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 1, 1, 1, 1, ones, ones, 5'd31);
    step(1, 0, 0, 1, 0, 1, 0, 0, 32'h42, 32'h43, 5'd3);
    // Stall together with flush
    step(1, 1, 1, 1, 1, 1, 1, 1, ones, ones, 5'd7);
    // Write to register 0 never forwards
    step(1, 0, 0, 1, 0, 1, 0, 0, 32'h99, 32'h1, 5'd0);
    // Reset during a stall
    step(1, 0, 0, 1, 0, 1, 1, 0, 32'h5A, 32'h5B, 5'd4);
    step(1, 1, 0, 1, 0, 1, 0, 0, 32'h1, 32'h2, 5'd6);
    step(0, 1, 0, 1, 0, 1, 0, 0, 32'h1, 32'h2, 5'd6);
    // Counter mix: 4 valid loads, 2 flushes, 3 stalls
    for (int i = 0; i < 4; i++)
      step(1, 0, 0, 1, 0, 1, 0, 0, i, i, 5'd2);
    step(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 5'd2);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 5'd2);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 5'd2);
    step(1, 1, 1, 1, 0, 1, 0, 0, 0, 0, 5'd2);
    step(1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 5'd2);
    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) != 0),
           ($urandom_range(0, 4) == 0),
           ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 3) != 0),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom_range(0, 1), $urandom_range(0, 1),
           $urandom, $urandom,
           ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
    end
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d required=0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_mem_register.md
# ex_mem_register

Pipeline register between the Execute stage and the Memory stage of the simplified MIPS pipeline. It captures the Execute results and control bits each cycle, and supports stall (hold) and flush (bubble insertion). It tracks instruction validity, suppresses side-effecting control bits for bubbles, and drives EX-hazard forwarding information back to Execute.

## Interface
Parameters:
- DATA_WIDTH, 32, width of ALU result and store data
- REG_ADDR_WIDTH, 5, register-file address width

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge
- reset  input  1  synchronous, active-low reset; one clock, reset is synchronous and active-low
- stall  input  1  hold all registered contents this cycle
- flush  input  1  load a bubble this cycle
- validInput  input  1  Execute holds a real instruction
- memToRegInput, regWriteInput, memWriteInput, memReadInput  input  1 each  control bits from Execute
- aluResultInput  input  DATA_WIDTH  ALU result / effective address
- memWriteDataInput  input  DATA_WIDTH  store data (rt after forwarding)
- regWriteAddressInput  input  REG_ADDR_WIDTH  destination register
- validOutput  output  1  registered instruction is real
- memToRegOutput, regWriteOutput, memWriteOutput, memReadOutput  output  1 each  registered control, gated by valid
- aluResultOutput  output  DATA_WIDTH  registered ALU result
- memWriteDataOutput  output  DATA_WIDTH  registered store data
- regWriteAddressOutput  output  REG_ADDR_WIDTH  registered destination
- forwardEnableOutput  output  1  ALU result may be forwarded to Execute
- loadPendingOutput  output  1  valid load in this slot; Execute cannot forward its result

## Operation
- Update priority on each rising clk: reset low > flush > stall > normal load.
- Reset (reset==0): all outputs 0, including validOutput and all data and address fields.
- Flush: validOutput<=0. All four control bits <=0. Data and address fields <=0. Flush wins over a simultaneous stall.
- Stall (flush==0): every register holds its value. Inputs are ignored.
- Normal load: validOutput<=validInput. Control bits <= input & validInput, so a bubble never writes the register file or memory. Data and address fields are loaded unconditionally.
- forwardEnableOutput = validOutput & regWriteOutput & ~memToRegOutput & (regWriteAddressOutput != 0). It is combinational from the registers.
- loadPendingOutput = validOutput & memReadOutput & memToRegOutput. It is combinational.
- Invariant: validOutput==0 implies regWriteOutput, memWriteOutput, memReadOutput and memToRegOutput are all 0.
- No arithmetic is performed. Widths pass through unchanged. Register 0 is never forwarded.

## Timing
- Latency: exactly 1 cycle from inputs to outputs when stall==0.
- Stall held for N cycles: outputs are constant for N cycles. The new value appears the cycle after stall deasserts.
- Flush effect is visible on the clock edge following the flush assertion.
- Reset asserted mid-stall or mid-flush: reset state on the next edge. First load occurs on the first edge with reset==1.
- Forwarding and hazard outputs change only after clock edges. They never combinationally depend on inputs.

## Configuration
- Macro EX_MEM_PERF_COUNTERS_EN. When defined, adds three 32-bit outputs:
  - retiredCountOutput: counts edges where a valid instruction is loaded.
  - bubbleCountOutput: counts edges that load a bubble, via flush or validInput==0.
  - stallCountOutput: counts edges with stall==1 and flush==0.
- Counters are all 0 on reset and wrap from 0xFFFFFFFF to 0.
- When the macro is undefined, these ports and counters do not exist. All other behaviour is identical.

## Test plan
- Reset, then load validInput=1, regWrite=1, aluResult=0x0000_1234, addr=5 → next cycle: validOutput=1, aluResultOutput=0x1234, forwardEnableOutput=1.
- Load with validInput=0, regWriteInput=1, memWriteInput=1 → regWriteOutput=0, memWriteOutput=0, validOutput=0.
- Load a valid lw (memRead=1, memToReg=1, addr=8), then stall 3 cycles while inputs change to 0xFFFF_FFFF → outputs unchanged for 3 cycles, loadPendingOutput=1, forwardEnableOutput=0.
- Assert stall and flush together on a valid instruction → next cycle validOutput=0, all control bits 0, aluResultOutput=0.
- Valid regWrite to addr=0 → forwardEnableOutput=0. Drive reset=0 during a stall → next cycle all outputs 0.
- With EX_MEM_PERF_COUNTERS_EN: 4 valid loads, 2 flushes, 3 stalls → retired=4, bubble=2, stall=3. Preload to 0xFFFF_FFFF via a long run and check the counter wraps to 0.
